dht11_scheduler: RTL and testbench

DHT11_SCHEDULER -- requirements
Module: dht11_scheduler

---
 rtl/dht11_scheduler_if.sv | 20 ++
 rtl/dht11_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_dht11_scheduler.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dht11_scheduler_if.sv
// APB slave bundle for the DHT11 measurement scheduler register block.
interface dht11_scheduler_if;
    logic [31:0] PADDR;
    logic        PWRITE;
    logic        PSEL;
    logic        PENABLE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;

    modport master (
        output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        input  PRDATA, PREADY
    );

    modport slave (
        input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
        output PRDATA, PREADY
    );
endinterface

// File: rtl/dht11_scheduler.sv
// DHT11 measurement scheduler: APB registers, ms prescaler, periodic/one-shot
// triggering with timeout, bounded retries and result latching.
module dht11_scheduler #(
    parameter int unsigned TICK_DIV     = 100_000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RETRY_GAP_MS = 1000
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    dht11_scheduler_if.slave        bus,
    output logic                    meas_start,
    input  logic                    meas_done,
    input  logic                    meas_ok,
    input  logic [13:0]             humidity,
    input  logic [13:0]             temperature,
    output logic                    irq
);

    localparam int unsigned PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned GAP_W      = (RETRY_GAP_MS > 0) ? $clog2(RETRY_GAP_MS + 1) : 1;
    localparam int unsigned TRY_W      = $clog2(MAX_RETRY + 2);
    localparam int unsigned MIN_PERIOD = 2000;

    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_PERIOD  = 5'h04;
    localparam logic [4:0] A_TIMEOUT = 5'h08;
    localparam logic [4:0] A_STATUS  = 5'h0C;
    localparam logic [4:0] A_HUM     = 5'h10;
    localparam logic [4:0] A_TEMP    = 5'h14;
    localparam logic [4:0] A_SAMPLE  = 5'h18;
    localparam logic [4:0] A_ERRCNT  = 5'h1C;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        GAP     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_cnt;
    logic               tick;
    logic [15:0]        period_cnt;
    logic [7:0]         to_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [TRY_W-1:0]   try_cnt, try_nxt;

    logic               en_q, irq_en_q;
    logic [15:0]        period_q;
    logic [7:0]         timeout_q;
    logic               valid_q, err_q, irq_pend_q;
    logic [3:0]         att_q;
    logic [13:0]        hum_q, temp_q;
    logic [15:0]        sample_q, errcnt_q;

    logic               acc, wr;
    logic [4:0]         addr;
    logic               wr_ctrl, wr_period, wr_timeout, wr_status;
    logic               oneshot, abort;
    logic [15:0]        eff_period;
    logic [7:0]         eff_timeout;
    logic               start, success, fail, final_fail;
    logic [31:0]        rdata;
    logic               unused_bits;

    // APB access decode; zero wait states
    assign acc         = bus.PSEL & bus.PENABLE;
    assign wr          = acc & bus.PWRITE;
    assign addr        = bus.PADDR[4:0];
    assign bus.PREADY  = acc & ~PRESET;
    assign wr_ctrl     = wr && (addr == A_CTRL);
    assign wr_period   = wr && (addr == A_PERIOD);
    assign wr_timeout  = wr && (addr == A_TIMEOUT);
    assign wr_status   = wr && (addr == A_STATUS);
    assign oneshot     = wr_ctrl & bus.PWDATA[1];
    assign abort       = wr_ctrl & bus.PWDATA[3];
    assign unused_bits = ^{bus.PADDR[31:5], bus.PWDATA[31:16]};

    assign eff_period  = (period_q < 16'(MIN_PERIOD)) ? 16'(MIN_PERIOD) : period_q;
    assign eff_timeout = (timeout_q == 8'd0) ? 8'd1 : timeout_q;
    assign try_nxt     = try_cnt + TRY_W'(1);

    assign meas_start  = (state_q == MEASURE);
    assign irq         = irq_pend_q & irq_en_q;

    // Free-running 1 ms prescaler
    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET)    pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + PRE_W'(1);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and completion events; a result beats a same-cycle timeout
    always_comb begin
        state_d    = state_q;
        start      = 1'b0;
        success    = 1'b0;
        fail       = 1'b0;
        final_fail = 1'b0;
        case (state_q)
            IDLE: begin
                if (oneshot || (en_q && (period_cnt >= eff_period))) begin
                    start   = 1'b1;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (meas_done) begin
                    if (meas_ok) begin
                        success = 1'b1;
                        state_d = IDLE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (to_cnt >= eff_timeout) begin
                    fail = 1'b1;
                end
                if (fail) begin
                    if (32'(try_nxt) <= MAX_RETRY) begin
                        state_d = GAP;
                    end else begin
                        final_fail = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            GAP: begin
                if (abort)                                  state_d = IDLE;
                else if (gap_cnt >= GAP_W'(RETRY_GAP_MS))   state_d = MEASURE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ms timers; timeout and gap timers restart every time their state is entered
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            period_cnt <= '0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            try_cnt    <= '0;
        end else begin
            if (start || wr_period || !en_q)      period_cnt <= '0;
            else if ((state_q == IDLE) && tick)   period_cnt <= period_cnt + 16'd1;

            if (state_q != MEASURE)               to_cnt <= '0;
            else if (tick)                        to_cnt <= to_cnt + 8'd1;

            if (state_q != GAP)                   gap_cnt <= '0;
            else if (tick)                        gap_cnt <= gap_cnt + GAP_W'(1);

            if (start)                            try_cnt <= '0;
            else if (fail)                        try_cnt <= try_nxt;
        end
    end

    // Control/status registers and latched results
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= 16'(MIN_PERIOD);
            timeout_q  <= 8'd50;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            att_q      <= '0;
            hum_q      <= '0;
            temp_q     <= '0;
            sample_q   <= '0;
            errcnt_q   <= '0;
        end else begin
            if (wr_ctrl) begin
                en_q     <= bus.PWDATA[0];
                irq_en_q <= bus.PWDATA[2];
            end
            if (wr_period)  period_q  <= bus.PWDATA[15:0];
            if (wr_timeout) timeout_q <= bus.PWDATA[7:0];

            if (success) begin
                hum_q   <= humidity;
                temp_q  <= temperature;
                valid_q <= 1'b1;
                err_q   <= 1'b0;
                att_q   <= 4'(try_nxt);
                if (sample_q != 16'hFFFF) sample_q <= sample_q + 16'd1;
            end
            if (final_fail) begin
                err_q <= 1'b1;
                att_q <= 4'(try_nxt);
                if (errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
            end

            if (success || final_fail)            irq_pend_q <= 1'b1;
            else if (wr_status && bus.PWDATA[3])  irq_pend_q <= 1'b0;
        end
    end

    // Read mux, driven only during a read access phase
    always_comb begin
        rdata = '0;
        if (acc && !bus.PWRITE) begin
            case (addr)
                A_CTRL:    rdata = 32'({irq_en_q, 1'b0, en_q});
                A_PERIOD:  rdata = 32'(period_q);
                A_TIMEOUT: rdata = 32'(timeout_q);
                A_STATUS:  rdata = 32'({att_q, irq_pend_q, err_q, valid_q, (state_q != IDLE)});
                A_HUM:     rdata = 32'(hum_q);
                A_TEMP:    rdata = 32'(temp_q);
                A_SAMPLE:  rdata = 32'(sample_q);
                A_ERRCNT:  rdata = 32'(errcnt_q);
                default:   rdata = '0;
            endcase
        end
    end

    assign bus.PRDATA = rdata;

endmodule

// File: tb/tb_dht11_scheduler.sv
// Randomized bench for dht11_scheduler: a transaction-level model predicts the
// register outcome of every measurement; pulse/gap/period widths are range-checked.
module tb_dht11_scheduler;

    localparam int unsigned TD     = 4;
    localparam int unsigned MR     = 3;
    localparam int unsigned GAP_MS = 20;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        meas_start, meas_done, meas_ok, irq;
    logic [13:0] humidity, temperature;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    logic        m_valid = 1'b0, m_err = 1'b0, m_irq = 1'b0;
    logic [3:0]  m_att = '0;
    logic [13:0] m_hum = '0, m_temp = '0;
    logic [15:0] m_samp = '0, m_errc = '0;
    logic [31:0] ctrl_v = '0;

    dht11_scheduler_if bus();

    dht11_scheduler #(.TICK_DIV(TD), .MAX_RETRY(MR), .RETRY_GAP_MS(GAP_MS)) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .bus         (bus),
        .meas_start  (meas_start),
        .meas_done   (meas_done),
        .meas_ok     (meas_ok),
        .humidity    (humidity),
        .temperature (temperature),
        .irq         (irq)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic apb_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = {27'($urandom), a}; bus.PWDATA = d;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b0; bus.PENABLE = 1'b0;
        bus.PADDR = {27'($urandom), a};
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        #1;
        check($sformatf("%s_pready", tag), 32'(bus.PREADY), 32'd1);
        check(tag, bus.PRDATA, exp);
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    endtask

    task automatic wait_ms(input logic lvl, input int budget, output int c);
        c = 0;
        while (meas_start !== lvl && c < budget) begin
            @(negedge PCLK);
            c++;
        end
    endtask

    task automatic range_chk(input string tag, input int v, input int lo, input int hi);
        check($sformatf("%s(len=%0d range=%0d..%0d)", tag, v, lo, hi),
              32'((v >= lo) && (v <= hi)), 32'd1);
    endtask

    task automatic respond(input bit ok, output logic [13:0] h, output logic [13:0] t);
        h = 14'($urandom); t = 14'($urandom);
        meas_done = 1'b1; meas_ok = ok; humidity = h; temperature = t;
        @(negedge PCLK);
        meas_done = 1'b0; meas_ok = 1'($urandom);
        humidity = 14'($urandom); temperature = 14'($urandom);
        check("start_drop_after_done", 32'(meas_start), 32'd0);
    endtask

    task automatic model_success(input int k, input logic [13:0] h, input logic [13:0] t);
        m_hum = h; m_temp = t; m_valid = 1'b1; m_err = 1'b0; m_irq = 1'b1; m_att = 4'(k);
        if (m_samp != 16'hFFFF) m_samp = m_samp + 16'd1;
    endtask

    task automatic model_final_fail(input int k);
        m_err = 1'b1; m_irq = 1'b1; m_att = 4'(k);
        if (m_errc != 16'hFFFF) m_errc = m_errc + 16'd1;
    endtask

    task automatic chk_regs(input string tag);
        rd_chk($sformatf("%s_status", tag), 5'h0C, 32'({m_att, m_irq, m_err, m_valid, 1'b0}));
        rd_chk($sformatf("%s_hum", tag), 5'h10, 32'(m_hum));
        rd_chk($sformatf("%s_temp", tag), 5'h14, 32'(m_temp));
        rd_chk($sformatf("%s_samples", tag), 5'h18, 32'(m_samp));
        rd_chk($sformatf("%s_errcnt", tag), 5'h1C, 32'(m_errc));
        check($sformatf("%s_irq", tag), 32'(irq), 32'(m_irq & ctrl_v[2]));
        check($sformatf("%s_start_low", tag), 32'(meas_start), 32'd0);
    endtask

    // One triggered measurement: outcome per attempt 0=no reply, 1=bad checksum, else ok
    task automatic run_meas(input int to_ms, input bit rnd, input logic [7:0] plan);
        int c, oc, ms;
        logic [13:0] h, t;
        ms = (to_ms == 0) ? 1 : to_ms;
        wait_ms(1'b1, 64, c);
        check("first_start_seen", 32'(c < 64), 32'd1);
        for (int k = 1; k <= int'(MR) + 1; k++) begin
            oc = rnd ? int'($urandom_range(2, 0)) : int'(plan[2*(k-1) +: 2]);
            if (oc == 0) begin
                wait_ms(1'b0, ms*TD + 8, c);
                range_chk($sformatf("timeout_pulse_a%0d", k), c, (ms-1)*TD + 1, ms*TD + 2);
            end else begin
                repeat ($urandom_range((ms-1)*TD, 1)) @(negedge PCLK);
                respond(oc != 1, h, t);
            end
            if (oc >= 2) begin
                model_success(k, h, t);
                return;
            end
            if (k == int'(MR) + 1) begin
                model_final_fail(k);
                return;
            end
            wait_ms(1'b1, GAP_MS*TD + 8, c);
            range_chk($sformatf("retry_gap_a%0d", k), c, (GAP_MS-1)*TD + 1, GAP_MS*TD + 2);
        end
    endtask

    initial begin
        int c, d;
        logic [31:0] v;
        logic [13:0] h, t;

        meas_done = 1'b0; meas_ok = 1'b0; humidity = '0; temperature = '0;
        bus.PADDR = '0; bus.PWDATA = '0; bus.PWRITE = 1'b0;
        bus.PSEL = 1'b1; bus.PENABLE = 1'b1;
        PRESET = 1'b1;
        repeat (3) @(negedge PCLK);
        check("rst_pready", 32'(bus.PREADY), 32'd0);
        check("rst_meas_start", 32'(meas_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
        PRESET = 1'b0;

        rd_chk("rst_ctrl", 5'h00, 32'd0);
        rd_chk("rst_period", 5'h04, 32'd2000);
        rd_chk("rst_timeout", 5'h08, 32'd50);
        chk_regs("rst");
        apb_wr(5'h02, 32'hFFFF_FFFF);
        rd_chk("unmapped_rd", 5'h02, 32'd0);
        rd_chk("unmapped_wr_ctrl", 5'h00, 32'd0);

        // Directed one-shot with IRQ enabled, reply 5 ms in
        ctrl_v = 32'h4;
        apb_wr(5'h00, 32'h6);
        wait_ms(1'b1, 64, c);
        repeat (5*TD) @(negedge PCLK);
        meas_done = 1'b1; meas_ok = 1'b1; humidity = 14'd45; temperature = 14'd2350;
        @(negedge PCLK);
        meas_done = 1'b0; meas_ok = 1'b0;
        model_success(1, 14'd45, 14'd2350);
        rd_chk("oneshot_status", 5'h0C, 32'h1A);
        chk_regs("oneshot");
        rd_chk("ctrl_selfclear", 5'h00, 32'h4);

        apb_wr(5'h08, 32'd5);
        rd_chk("timeout_rb", 5'h08, 32'd5);

        // Randomized measurements, IRQ enable and STATUS writes
        for (int i = 0; i < 12; i++) begin
            ctrl_v = 32'($urandom_range(1, 0)) << 2;
            apb_wr(5'h00, ctrl_v | 32'h2);
            run_meas(5, 1'b1, 8'h00);
            chk_regs($sformatf("rnd%0d", i));
            v = $urandom;
            apb_wr(5'h0C, v);
            if (v[3]) m_irq = 1'b0;
            check($sformatf("rnd%0d_irq_after_w1c", i), 32'(irq), 32'(m_irq & ctrl_v[2]));
        end

        // Four silent attempts, then a bad-then-good sequence
        apb_wr(5'h00, ctrl_v | 32'h2);
        run_meas(5, 1'b0, 8'h00);
        chk_regs("all_timeout");
        apb_wr(5'h00, ctrl_v | 32'h2);
        run_meas(5, 1'b0, 8'h09);
        chk_regs("bad_then_ok");

        // TIMEOUT=0 behaves as 1 ms
        apb_wr(5'h08, 32'd0);
        apb_wr(5'h00, ctrl_v | 32'h2);
        run_meas(0, 1'b0, 8'h00);
        chk_regs("timeout_zero");
        apb_wr(5'h08, 32'd5);

        // ABORT in GAP; measure the exact timeout pulse from an aligned start
        while ((cyc % TD) != 0) @(negedge PCLK);
        apb_wr(5'h00, ctrl_v | 32'h2);
        wait_ms(1'b1, 64, c);
        wait_ms(1'b0, 5*TD + 8, d);
        range_chk("abort_run_pulse", d, 4*TD + 1, 5*TD + 2);
        repeat (4) @(negedge PCLK);
        apb_wr(5'h00, ctrl_v | 32'h8);
        chk_regs("abort_gap");
        wait_ms(1'b1, GAP_MS*TD + 10, c);
        check("abort_no_restart", 32'(c >= int'(GAP_MS*TD) + 10), 32'd1);

        // Result on the same cycle the timeout is reached
        while ((cyc % TD) != 0) @(negedge PCLK);
        apb_wr(5'h00, ctrl_v | 32'h2);
        wait_ms(1'b1, 64, c);
        repeat ((d > 1) ? d - 1 : 0) @(negedge PCLK);
        respond(1'b1, h, t);
        model_success(1, h, t);
        wait_ms(1'b1, GAP_MS*TD + 10, c);
        check("coincident_no_retry", 32'(c >= int'(GAP_MS*TD) + 10), 32'd1);
        chk_regs("coincident");

        // W1C IRQ_PEND on the very cycle a success sets it
        ctrl_v = 32'h4;
        apb_wr(5'h0C, 32'h8);
        m_irq = 1'b0;
        apb_wr(5'h00, 32'h6);
        rd_chk("w1c_pre_status", 5'h0C, 32'({m_att, 1'b0, m_err, m_valid, 1'b1}));
        wait_ms(1'b1, 64, c);
        @(negedge PCLK);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PENABLE = 1'b0;
        bus.PADDR = 32'h0C; bus.PWDATA = 32'h8;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        h = 14'($urandom); t = 14'($urandom);
        meas_done = 1'b1; meas_ok = 1'b1; humidity = h; temperature = t;
        @(negedge PCLK);
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        meas_done = 1'b0; meas_ok = 1'b0;
        model_success(1, h, t);
        chk_regs("w1c_collide");

        // Periodic mode with an out-of-range PERIOD, then EN dropped mid-measure
        apb_wr(5'h04, 32'd100);
        ctrl_v = 32'h5;
        apb_wr(5'h00, ctrl_v);
        wait_ms(1'b1, 2000*TD + TD + 8, c);
        range_chk("period_first", c, 1999*TD - 2, 2000*TD + 4);
        repeat ($urandom_range(2*TD, 1)) @(negedge PCLK);
        respond(1'b1, h, t);
        model_success(1, h, t);
        wait_ms(1'b1, 2000*TD + TD + 8, c);
        range_chk("period_second", c, 1999*TD + 1, 2000*TD + 2);
        ctrl_v = 32'h4;
        apb_wr(5'h00, ctrl_v);
        repeat ($urandom_range(2*TD, 1)) @(negedge PCLK);
        respond(1'b1, h, t);
        model_success(1, h, t);
        wait_ms(1'b1, 2000*TD + TD + 8, c);
        check("period_stops_en0", 32'(c >= int'(2000*TD + TD) + 8), 32'd1);
        chk_regs("periodic");

        // Reset mid-measurement drops meas_start without a clock edge
        apb_wr(5'h00, 32'h2);
        wait_ms(1'b1, 64, c);
        #2;
        PRESET = 1'b1;
        #1;
        check("async_reset_drop", 32'(meas_start), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
